// File: rtl/seq_detect_pkg.sv
// Shared types and default sizing for the multi-pattern serial sequence detector.
package seq_detect_pkg;

    // Global matching mode: overlapping matches, or restart after each match.
    typedef enum logic {
        MODE_OVERLAP = 1'b0,
        MODE_NONOVL  = 1'b1
    } mode_t;

    localparam int N_DEF  = 6;  // pattern / history width
    localparam int M_DEF  = 4;  // number of channels
    localparam int CW_DEF = 8;  // match counter width

endpackage

// File: rtl/seq_detect_chan.sv
// One detector channel: programmable seq/mask, fill guard, registered hit pulse
// and a saturating match counter.
module seq_detect_chan
    import seq_detect_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  hist_nxt,   // history as it will be after this cycle's shift
    input  logic          en,
    input  mode_t         mode,
    input  logic          cfg_we,     // already decoded for this channel
    input  logic [N-1:0]  cfg_seq,
    input  logic [N-1:0]  cfg_mask,
    input  logic          clr_cnt,
    output logic          hit,
    output logic [CW-1:0] cnt
);

    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(N);
    localparam logic [FW-1:0] FILL_ARM  = FW'(N - 1);  // one more bit completes a window
    localparam logic [CW-1:0] CNT_MAX   = '1;

    logic [N-1:0]  seq_q,  seq_d;
    logic [N-1:0]  mask_q, mask_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          hit_q,  hit_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          match;

    // Next-state: compare, fill tracking, config write and counter update.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can infer a latch.
        seq_d  = seq_q;
        mask_d = mask_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;

        // A write to this channel blocks matching in the same cycle; a zero mask disables it.
        match = en && !cfg_we && (mask_q != '0)
              && (&((hist_nxt ~^ seq_q) | ~mask_q))
              && (fill_q >= FILL_ARM);
        hit_d = match;

        if (cfg_we) begin
            seq_d  = cfg_seq;
            mask_d = cfg_mask;
            fill_d = '0;
        end else if (en) begin
            if (match && (mode == MODE_NONOVL)) begin
                fill_d = '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end

        // Clear wins over a coincident match; the hit pulse is unaffected.
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: seq/mask are reset like any other state so every channel wakes up disabled.
            seq_q  <= '0;
            mask_q <= '0;
            fill_q <= '0;
            hit_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            seq_q  <= seq_d;
            mask_q <= mask_d;
            fill_q <= fill_d;
            hit_q  <= hit_d;
            cnt_q  <= cnt_d;
        end
    end

    assign hit = hit_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/multi_seq_detect.sv
// Serial multi-pattern sequence detector: shared shift history feeding M
// independently programmable channels, plus hit priority encoder and count mux.
module multi_seq_detect
    import seq_detect_pkg::*;
#(
    parameter  int N  = N_DEF,
    parameter  int M  = M_DEF,
    parameter  int CW = CW_DEF,
    localparam int IW = (M > 1) ? $clog2(M) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          a,
    input  logic          en,
    input  logic          mode,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [N-1:0]  cfg_seq,
    input  logic [N-1:0]  cfg_mask,
    input  logic          clr_cnt,
    input  logic [IW-1:0] cnt_sel,
    output logic [M-1:0]  hit,
    output logic          hit_any,
    output logic [IW-1:0] hit_idx,
    output logic [CW-1:0] cnt_out
);

    logic [N-1:0]  hist_q, hist_d;
    logic [CW-1:0] cnt_arr [M];

    // Shift the new bit in at the LSB only on enabled cycles.
    always_comb begin
        hist_d = en ? {hist_q[N-2:0], a} : hist_q;
    end

    // Shared history register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    // Channels compare against the post-shift history; cfg_idx values >= M decode to nothing.
    for (genvar i = 0; i < M; i++) begin : g_chan
        seq_detect_chan #(
            .N  (N),
            .CW (CW)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .hist_nxt (hist_d),
            .en       (en),
            .mode     (mode_t'(mode)),
            .cfg_we   (cfg_we && (cfg_idx == IW'(i))),
            .cfg_seq  (cfg_seq),
            .cfg_mask (cfg_mask),
            .clr_cnt  (clr_cnt),
            .hit      (hit[i]),
            .cnt      (cnt_arr[i])
        );
    end

    assign hit_any = |hit;

    // Lowest-index hit wins; scanning downward leaves the lowest set index last.
    always_comb begin
        hit_idx = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_idx = IW'(i);
            end
        end
    end

    // Counter readback; selects with no matching channel read as zero.
    always_comb begin
        cnt_out = '0;
        for (int i = 0; i < M; i++) begin
            if (cnt_sel == IW'(i)) begin
                cnt_out = cnt_arr[i];
            end
        end
    end

endmodule

// File: tb/tb_multi_seq_detect.sv
// Self-checking bench for multi_seq_detect (N=6, M=4, CW=8).
module tb_multi_seq_detect;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       a, en, mode, cfg_we, clr_cnt;
    logic [1:0] cfg_idx, cnt_sel;
    logic [5:0] cfg_seq, cfg_mask;
    logic [3:0] hit;
    logic       hit_any;
    logic [1:0] hit_idx;
    logic [7:0] cnt_out;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       a;
        logic       en;
        logic       clr;
        logic [3:0] hit;
        logic [7:0] cnt;
    } vec_t;

    typedef struct {
        logic [3:0] hit;
        logic [7:0] cnt;
        string      tag;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    multi_seq_detect #(.N(6), .M(4), .CW(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .a        (a),
        .en       (en),
        .mode     (mode),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_seq  (cfg_seq),
        .cfg_mask (cfg_mask),
        .clr_cnt  (clr_cnt),
        .cnt_sel  (cnt_sel),
        .hit      (hit),
        .hit_any  (hit_any),
        .hit_idx  (hit_idx),
        .cnt_out  (cnt_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] low_idx(input logic [3:0] h);
        logic [1:0] r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (h[i]) r = i[1:0];
        end
        return r;
    endfunction

    // Drive one cycle (caller is at a negedge), push the expectation, then
    // pop and compare once the DUT has registered the result.
    task automatic drive_check(input logic a_i, input logic en_i, input logic clr_i,
                               input logic [3:0] e_hit, input logic [7:0] e_cnt,
                               input string tag);
        exp_t e;
        a       = a_i;
        en      = en_i;
        clr_cnt = clr_i;
        exp_q.push_back('{e_hit, e_cnt, tag});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({e.tag, ".hit"},     32'(hit),     32'(e.hit));
        check({e.tag, ".hit_any"}, 32'(hit_any), 32'(|e.hit));
        check({e.tag, ".hit_idx"}, 32'(hit_idx), 32'(low_idx(e.hit)));
        check({e.tag, ".cnt"},     32'(cnt_out), 32'(e.cnt));
    endtask

    task automatic step(input logic a_i, input logic en_i, input logic clr_i,
                        input logic [3:0] e_hit, input logic [7:0] e_cnt, input string tag);
        @(negedge clk);
        drive_check(a_i, en_i, clr_i, e_hit, e_cnt, tag);
    endtask

    task automatic cfg_step(input logic [1:0] idx, input logic [5:0] seq, input logic [5:0] mask,
                            input logic a_i, input logic en_i,
                            input logic [3:0] e_hit, input logic [7:0] e_cnt, input string tag);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_seq  = seq;
        cfg_mask = mask;
        drive_check(a_i, en_i, 1'b0, e_hit, e_cnt, tag);
        cfg_we   = 1'b0;
    endtask

    task automatic add(input logic a_i, input logic en_i, input logic clr_i,
                       input logic [3:0] h, input logic [7:0] c);
        tbl.push_back('{a_i, en_i, clr_i, h, c});
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            step(tbl[i].a, tbl[i].en, tbl[i].clr, tbl[i].hit, tbl[i].cnt,
                 $sformatf("%s[%0d]", tag, i));
        end
        tbl.delete();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        a = 1'b0; en = 1'b0; clr_cnt = 1'b0; cfg_we = 1'b0;
        #2;
        check({tag, ".rst_hit"}, 32'(hit),     32'd0);
        check({tag, ".rst_cnt"}, 32'(cnt_out), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [5:0] gap_bits;

    initial begin
        reset_n  = 1'b1;
        a = 1'b0; en = 1'b0; mode = 1'b0; cfg_we = 1'b0; clr_cnt = 1'b0;
        cfg_idx  = 2'd0; cfg_seq = '0; cfg_mask = '0; cnt_sel = 2'd0;
        #3 reset_n = 1'b0;
        #9;
        // Reset state on every output and every counter select.
        check("reset.hit",     32'(hit),     32'd0);
        check("reset.hit_any", 32'(hit_any), 32'd0);
        check("reset.hit_idx", 32'(hit_idx), 32'd0);
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            #1;
            check($sformatf("reset.cnt%0d", s), 32'(cnt_out), 32'd0);
        end
        cnt_sel = 2'd0;
        @(negedge clk);
        reset_n = 1'b1;

        // Fill guard: all-zero pattern must not match the reset-filled history.
        cfg_step(2'd0, 6'b000000, 6'b111111, 1'b0, 1'b0, 4'b0000, 8'd0, "fill.cfg");
        for (int k = 0; k < 5; k++) add(1'b0, 1'b1, 1'b0, 4'b0000, 8'd0);
        add(1'b0, 1'b1, 1'b0, 4'b0001, 8'd1);
        add(1'b1, 1'b0, 1'b0, 4'b0000, 8'd1);
        run_table("fill");

        // Overlap mode: 10101010 hits after bits 6 and 8.
        do_reset("ovl");
        mode = 1'b0;
        cfg_step(2'd0, 6'b101010, 6'b111111, 1'b0, 1'b0, 4'b0000, 8'd0, "ovl.cfg");
        for (int k = 0; k < 8; k++)
            add((k % 2 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0,
                (k == 5 || k == 7) ? 4'b0001 : 4'b0000,
                (k < 5) ? 8'd0 : (k < 7) ? 8'd1 : 8'd2);
        run_table("ovl");

        // Non-overlap mode: only the first window matches.
        do_reset("nonovl");
        mode = 1'b1;
        cfg_step(2'd0, 6'b101010, 6'b111111, 1'b0, 1'b0, 4'b0000, 8'd0, "nonovl.cfg");
        for (int k = 0; k < 8; k++)
            add((k % 2 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0,
                (k == 5) ? 4'b0001 : 4'b0000,
                (k < 5) ? 8'd0 : 8'd1);
        run_table("nonovl");

        // Mask with en gaps: idle cycles drive the opposite bit, which must be ignored.
        do_reset("mask");
        mode     = 1'b0;
        cnt_sel  = 2'd1;
        gap_bits = 6'b110101;
        cfg_step(2'd1, 6'b110000, 6'b110000, 1'b0, 1'b0, 4'b0000, 8'd0, "mask.cfg");
        for (int k = 0; k < 6; k++) begin
            add(gap_bits[5-k], 1'b1, 1'b0, (k == 5) ? 4'b0010 : 4'b0000, (k == 5) ? 8'd1 : 8'd0);
            add(~gap_bits[5-k], 1'b0, 1'b0, 4'b0000, (k == 5) ? 8'd1 : 8'd0);
        end
        run_table("mask");

        // Priority: ch1 and ch2 share a pattern; continuous ones hit every cycle.
        do_reset("prio");
        cnt_sel = 2'd2;
        cfg_step(2'd1, 6'b111111, 6'b111111, 1'b0, 1'b0, 4'b0000, 8'd0, "prio.cfg1");
        cfg_step(2'd2, 6'b111111, 6'b111111, 1'b0, 1'b0, 4'b0000, 8'd0, "prio.cfg2");
        for (int k = 0; k < 9; k++)
            add(1'b1, 1'b1, 1'b0, (k >= 5) ? 4'b0110 : 4'b0000, (k >= 5) ? 8'(k - 4) : 8'd0);
        run_table("prio");

        // Saturation at 255, then clear coincident with a hit.
        do_reset("sat");
        cnt_sel = 2'd0;
        cfg_step(2'd0, 6'b000001, 6'b000001, 1'b0, 1'b0, 4'b0000, 8'd0, "sat.cfg");
        for (int k = 1; k <= 300; k++)
            step(1'b1, 1'b1, 1'b0, (k >= 6) ? 4'b0001 : 4'b0000,
                 (k < 6) ? 8'd0 : ((k - 5) > 255) ? 8'd255 : 8'(k - 5),
                 $sformatf("sat[%0d]", k));
        step(1'b1, 1'b1, 1'b1, 4'b0001, 8'd0, "sat.clr_hit");
        step(1'b1, 1'b1, 1'b0, 4'b0001, 8'd1, "sat.after_clr");
        step(1'b0, 1'b0, 1'b1, 4'b0000, 8'd0, "sat.clr_idle");

        // Reconfig mid-stream: ch0 restarts its fill, ch3 keeps counting.
        do_reset("recfg");
        cnt_sel = 2'd3;
        cfg_step(2'd0, 6'b111111, 6'b111111, 1'b0, 1'b0, 4'b0000, 8'd0, "recfg.cfg0");
        cfg_step(2'd3, 6'b000001, 6'b000001, 1'b0, 1'b0, 4'b0000, 8'd0, "recfg.cfg3");
        for (int k = 1; k <= 4; k++)
            step(1'b1, 1'b1, 1'b0, 4'b0000, 8'd0, $sformatf("recfg.pre[%0d]", k));
        cfg_step(2'd0, 6'b111111, 6'b111111, 1'b1, 1'b1, 4'b0000, 8'd0, "recfg.wr_en");
        for (int k = 1; k <= 6; k++)
            step(1'b1, 1'b1, 1'b0, (k == 6) ? 4'b1001 : 4'b1000, 8'(k),
                 $sformatf("recfg.post[%0d]", k));

        // Reset while hits are active: outputs drop at once, channels come back disabled.
        reset_n = 1'b0;
        #1;
        check("midrst.hit",     32'(hit),     32'd0);
        check("midrst.hit_any", 32'(hit_any), 32'd0);
        check("midrst.hit_idx", 32'(hit_idx), 32'd0);
        check("midrst.cnt",     32'(cnt_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) add(1'b1, 1'b1, 1'b0, 4'b0000, 8'd0);
        run_table("midrst.after");

        check("scoreboard.empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
